// File: rtl/grant_burst_sequencer_pkg.sv
// Shared types and helpers for the grant burst sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gbs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } gbs_state_t;

  localparam int GBS_DEFAULT_TIMEOUT = 16;

  // Index of the set bit in a one-hot word (up to 32 requesters).
  // Only called after the caller has confirmed exactly one bit is set.
  function automatic int unsigned onehot_to_idx(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/grant_burst_sequencer_if.sv
// Arbiter-side and bus-side signals of the grant burst sequencer.
// Latency: n/a (wiring only).
// Backpressure: bus_ready from the shared resource stalls the owner's beat.
// Ports: grant/grant_valid/req_len/req_data from the arbiter side, beat_taken/release_pulse
//        back to it; bus_valid/bus_data/bus_owner/timeout_err towards the resource, bus_ready back.
interface grant_burst_sequencer_if #(
  parameter int N_MASTERS = 4,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 4
);
  localparam int OWN_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0]        grant;
  logic                        grant_valid;
  logic [N_MASTERS*LEN_W-1:0]  req_len;
  logic [N_MASTERS*DATA_W-1:0] req_data;
  logic [N_MASTERS-1:0]        beat_taken;
  logic                        release_pulse;  // "release" is a reserved word
  logic                        bus_valid;
  logic [DATA_W-1:0]           bus_data;
  logic [OWN_W-1:0]            bus_owner;
  logic                        bus_ready;
  logic                        timeout_err;

  // The sequencer drives the bus.
  modport master (
    input  grant, grant_valid, req_len, req_data, bus_ready,
    output beat_taken, release_pulse, bus_valid, bus_data, bus_owner, timeout_err
  );

  // Arbiter + masters + shared resource.
  modport slave (
    output grant, grant_valid, req_len, req_data, bus_ready,
    input  beat_taken, release_pulse, bus_valid, bus_data, bus_owner, timeout_err
  );
endinterface

// File: rtl/grant_burst_sequencer_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles, flags expiry on the TIMEOUT-th one.
// Latency: expire is combinational in the cycle the count sits at TIMEOUT-1 and inc is high.
// Backpressure: none; clear wins over inc.
// Ports: clock, reset_n (sync, active-low), clear, inc, expire.
module gbs_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic expire
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  assign expire = inc && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      cnt <= '0;
    end else if (inc && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/grant_burst_sequencer.sv
// Locks the arbiter's one-hot winner and streams its burst onto the shared bus, then pulses release.
// Latency: first beat on the bus 1 cycle after grant; release 1 cycle after the last beat or abort.
// Backpressure: bus_ready low stalls the beat; TIMEOUT consecutive stalls abort the tenure.
// Ports: clock, reset_n (sync, active-low), gbs (master modport of grant_burst_sequencer_if).
module grant_burst_sequencer
  import gbs_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 4,
  parameter int TIMEOUT   = GBS_DEFAULT_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  grant_burst_sequencer_if.master gbs
);
  localparam int OWN_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  gbs_state_t        state_q, state_d;
  logic [OWN_W-1:0]  owner_q;
  logic [LEN_W-1:0]  beats_q;     // remaining beats minus one
  logic              timeout_q;
  logic [OWN_W-1:0]  grant_idx;
  logic              grant_ok;
  logic              xfer_fire;
  logic              last_beat;
  logic              expire;
  logic              wd_clear;
  logic              wd_inc;

  assign grant_ok  = gbs.grant_valid && ($countones(gbs.grant) == 1);
  assign grant_idx = OWN_W'(onehot_to_idx(32'(gbs.grant)));
  assign xfer_fire = (state_q == XFER) && gbs.bus_ready;
  assign last_beat = (beats_q == '0);
  assign wd_inc    = (state_q == XFER) && !gbs.bus_ready;
  assign wd_clear  = (state_q != XFER) || gbs.bus_ready;

  gbs_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .inc     (wd_inc),
    .expire  (expire)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner / beat counter / abort flag. req_len is only looked at when locking.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      owner_q   <= '0;
      beats_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == IDLE && grant_ok) begin
        owner_q <= grant_idx;
        beats_q <= gbs.req_len[int'(grant_idx)*LEN_W +: LEN_W];
      end else if (xfer_fire && !last_beat) begin
        beats_q <= beats_q - LEN_W'(1);
      end
      // Registered on the XFER->RELEASE edge so it lines up with release_pulse.
      timeout_q <= (state_q == XFER) && expire;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_ok) state_d = XFER;
      XFER:    if ((xfer_fire && last_beat) || expire) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    gbs.bus_valid     = 1'b0;
    gbs.bus_data      = '0;
    gbs.bus_owner     = '0;
    gbs.beat_taken    = '0;
    gbs.release_pulse = 1'b0;
    gbs.timeout_err   = timeout_q;
    unique case (state_q)
      XFER: begin
        gbs.bus_valid = 1'b1;
        gbs.bus_data  = gbs.req_data[int'(owner_q)*DATA_W +: DATA_W];
        gbs.bus_owner = owner_q;
        if (gbs.bus_ready) gbs.beat_taken[owner_q] = 1'b1;
      end
      RELEASE: gbs.release_pulse = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_grant_burst_sequencer.sv
module tb_grant_burst_sequencer;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int LW    = 4;
  localparam int TMO   = 16;
  localparam int RDY_N = 512;

  typedef struct {
    int            cyc;
    bit            is_rel;
    bit            taken;
    int            owner;
    logic [DW-1:0] data;
    bit            tmo;
  } ev_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic rst_prev = 1'b0;
  ev_t  exp_q[$];
  ev_t  cur;
  bit   rdy_pat [0:RDY_N-1];
  logic [DW-1:0] bd [0:15];

  grant_burst_sequencer_if #(.N_MASTERS(N), .DATA_W(DW), .LEN_W(LW)) gbs();

  grant_burst_sequencer #(.N_MASTERS(N), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .gbs     (gbs)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_prev <= reset_n;
    mon_en   <= 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the event due this cycle, otherwise expects a quiet bus.
  always @(negedge clock) begin
    if (mon_en) begin
      if (!rst_prev) begin
        check("reset_outputs", 32'({gbs.bus_valid, gbs.beat_taken, gbs.release_pulse,
                                    gbs.timeout_err, gbs.bus_data, gbs.bus_owner}), 32'd0);
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        cur = exp_q.pop_front();
        if (cur.is_rel) begin
          check("release", 32'(gbs.release_pulse), 32'd1);
          check("timeout_err", 32'(gbs.timeout_err), 32'(cur.tmo));
          check("release_quiet", 32'({gbs.bus_valid, gbs.beat_taken}), 32'd0);
        end else begin
          check("bus_valid", 32'(gbs.bus_valid), 32'd1);
          check("bus_owner", 32'(gbs.bus_owner), 32'(cur.owner));
          check("bus_data", 32'(gbs.bus_data), 32'(cur.data));
          check("beat_taken", 32'(gbs.beat_taken), cur.taken ? 32'(1 << cur.owner) : 32'd0);
          check("xfer_quiet", 32'({gbs.release_pulse, gbs.timeout_err}), 32'd0);
        end
      end else begin
        check("idle_quiet", 32'({gbs.bus_valid, gbs.beat_taken, gbs.release_pulse,
                                 gbs.timeout_err}), 32'd0);
      end
    end
  end

  // Reference: bus cycles begin the cycle after the grant. Each cycle either moves
  // the current beat (ready) or stalls; the TMO-th consecutive stall aborts.
  // Release follows in the next cycle. Events after 'lim' are cut off by a reset.
  task automatic model_push(input int g, input int own, input int nb, input int lim,
                            output int rel);
    int t, k, stalls;
    bit abort;
    ev_t ev;
    t = 0; k = 0; stalls = 0; abort = 1'b0;
    while (k < nb && !abort) begin
      ev.cyc = g + 1 + t; ev.is_rel = 1'b0; ev.taken = rdy_pat[t];
      ev.owner = own; ev.data = bd[k]; ev.tmo = 1'b0;
      if (ev.cyc <= lim) exp_q.push_back(ev);
      if (rdy_pat[t]) begin
        k++;
        stalls = 0;
      end else begin
        stalls++;
        if (stalls == TMO) abort = 1'b1;
      end
      t++;
    end
    ev.cyc = g + 1 + t; ev.is_rel = 1'b1; ev.taken = 1'b0;
    ev.owner = own; ev.data = '0; ev.tmo = abort;
    if (ev.cyc <= lim) exp_q.push_back(ev);
    rel = g + 1 + t;
  endtask

  task automatic randomize_lanes(input int own, input logic [DW-1:0] d);
    for (int i = 0; i < N; i++) begin
      gbs.req_len[i*LW +: LW]  = 4'($urandom);
      gbs.req_data[i*DW +: DW] = 8'($urandom);
    end
    gbs.req_data[own*DW +: DW] = d;
  endtask

  function automatic logic [3:0] non_onehot();
    logic [3:0] v;
    do v = 4'($urandom_range(0, 15)); while ($countones(v) == 1);
    return v;
  endfunction

  // mode: 0 always ready, 1 random ready, 2 stuck low, 3 low for beat 2 during 3 cycles.
  // rst_at >= 0: reset asserted in that bus cycle of the tenure.
  task automatic tenure(input int own, input int len, input int mode, input int rst_at);
    int g, rel, stop, k, nb, lim;
    bit taken;
    nb = len + 1;
    for (int i = 0; i < 16; i++) bd[i] = 8'($urandom);
    for (int i = 0; i < RDY_N; i++) begin
      case (mode)
        0:       rdy_pat[i] = 1'b1;
        1:       rdy_pat[i] = ($urandom_range(0, 3) != 0);
        2:       rdy_pat[i] = 1'b0;
        default: rdy_pat[i] = !(i >= 1 && i <= 3);
      endcase
    end
    @(posedge clock); #1;
    g = cyc;
    k = 0;
    randomize_lanes(own, bd[0]);
    gbs.req_len[own*LW +: LW] = 4'(len);
    gbs.grant       = 4'(1 << own);
    gbs.grant_valid = 1'b1;
    gbs.bus_ready   = 1'($urandom);
    lim = (rst_at >= 0) ? g + 1 + rst_at : 32'h7fffffff;
    model_push(g, own, nb, lim, rel);
    stop = (rst_at >= 0) ? g + 1 + rst_at : rel;
    for (int o = 0; g + 1 + o <= stop; o++) begin
      @(negedge clock);
      taken = gbs.beat_taken[own];
      @(posedge clock); #1;
      if (taken && k < nb - 1) k++;
      randomize_lanes(own, bd[k]);
      gbs.bus_ready   = rdy_pat[o];
      gbs.grant       = 4'($urandom_range(0, 15));
      gbs.grant_valid = 1'($urandom);
      if (o == rst_at) begin
        reset_n = 1'b0;
        gbs.grant_valid = 1'b0;
      end
    end
    gbs.grant_valid = 1'b0;
    if (rst_at >= 0) begin
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset_n = 1'b1;
    end
  endtask

  task automatic idle(input int n, input logic [3:0] gw, input bit vld);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      gbs.grant       = gw;
      gbs.grant_valid = vld;
      gbs.bus_ready   = 1'($urandom);
      randomize_lanes(0, 8'($urandom));
    end
    gbs.grant_valid = 1'b0;
  endtask

  initial begin
    gbs.grant       = '0;
    gbs.grant_valid = 1'b0;
    gbs.req_len     = '0;
    gbs.req_data    = '0;
    gbs.bus_ready   = 1'b0;
    reset_n         = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    tenure(1, 3, 0, -1);                               // plain 4-beat burst
    tenure(1, 3, 3, -1);                               // beat 2 stalled 3 cycles
    tenure($urandom_range(0, 3), $urandom_range(0, 15), 2, -1);  // stuck bus -> abort
    tenure(0, 0, 0, -1);                               // granted right after abort, single beat
    idle(3, 4'b0110, 1'b1);                            // multi-hot ignored
    idle(3, 4'b0000, 1'b1);                            // zero grant ignored
    tenure(2, 3, 0, 1);                                // reset during beat 2 of 4
    tenure(3, $urandom_range(0, 15), 0, -1);           // fresh grant after reset
    tenure(2, 15, 0, -1);                              // longest burst
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), non_onehot(), 1'b1);
      tenure($urandom_range(0, 3), $urandom_range(0, 15),
             ($urandom_range(0, 5) == 0) ? 2 : 1, -1);
    end
    idle(4, 4'b0000, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
